// File: rtl/uart_frame_loader.sv
// uart_frame_loader: turns the uart_rx byte stream into sequential BRAM pixel
// writes. It can wait for a two-byte sync header first, packs 1 or 2 bytes per
// pixel, and flags the end of each frame. A stalled transfer (timeout), a UART
// stop-bit error or a host abort throws away the partial frame.
module uart_frame_loader #(
    parameter int          ADDR_W         = 19,
    parameter int          FRAME_PIXELS   = 307200,
    parameter int          BPP            = 1,
    parameter int          SYNC_EN        = 1,
    parameter logic [7:0]  SYNC0          = 8'hAA,
    parameter logic [7:0]  SYNC1          = 8'h55,
    parameter int          TIMEOUT_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                rx_frame_error,
    input  logic                abort,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [8*BPP-1:0]    wr_data,
    output logic                wr_en,
    output logic                frame_done,
    output logic                busy,
    output logic [7:0]          error_count,
    output logic [1:0]          state
);

    localparam int DATA_W = 8 * BPP;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC1 = 2'd1;
    localparam logic [1:0] ST_RECV  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [DATA_W-1:0] pix_buf;
    logic [DATA_W-1:0] pix_word;
    logic              byte_cnt;
    logic              last_pending;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] cur_idx;
    logic              in_frame;
    logic              byte_in;
    logic              pix_done;
    logic              timeout_hit;
    logic              flush;
    logic              count_err;

    // Decode the events of this cycle and the pixel that the current byte would complete.
    always_comb begin
        in_frame    = (state == ST_SYNC1) || (state == ST_RECV);
        byte_in     = rx_valid && !rx_frame_error;
        // Earlier bytes of the pixel shift towards the MSB; the new byte lands in the LSB.
        pix_word    = (pix_buf << 8) | DATA_W'(rx_data);
        pix_done    = (BPP == 1) || byte_cnt;
        // While a write is on the bus its address has not advanced yet, so the
        // next pixel index is one past it.
        cur_idx     = wr_en ? (wr_addr + ADDR_W'(1)) : wr_addr;
        timeout_hit = in_frame && !rx_valid && (to_cnt == TO_LAST);
        flush       = abort || (in_frame && ((rx_valid && rx_frame_error) || timeout_hit));
        count_err   = !abort && (((rx_valid && rx_frame_error) && (state != ST_DONE)) || timeout_hit);
    end

    assign busy = in_frame;

    // Saturating error counter for timeouts and UART frame errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_count <= '0;
        end else if (count_err && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
        end
    end

    // Main FSM: header detection, pixel packing, write generation and recovery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_en        <= 1'b0;
            frame_done   <= 1'b0;
            pix_buf      <= '0;
            byte_cnt     <= 1'b0;
            last_pending <= 1'b0;
            to_cnt       <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (!in_frame || rx_valid) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (flush) begin
                state        <= ST_IDLE;
                wr_addr      <= '0;
                pix_buf      <= '0;
                byte_cnt     <= 1'b0;
                last_pending <= 1'b0;
                to_cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (SYNC_EN == 0) begin
                            state <= ST_RECV;
                        end else if (byte_in && (rx_data == SYNC0)) begin
                            state <= ST_SYNC1;
                        end
                    end
                    ST_SYNC1: begin
                        if (byte_in) begin
                            if (rx_data == SYNC1) begin
                                state <= ST_RECV;
                            end else if (rx_data != SYNC0) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_RECV: begin
                        if (wr_en) begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                        // The frame is already full while its last write is on
                        // the bus; a byte arriving then has no pixel slot and is dropped.
                        if (last_pending) begin
                            state        <= ST_DONE;
                            frame_done   <= 1'b1;
                            wr_addr      <= '0;
                            last_pending <= 1'b0;
                        end else if (byte_in) begin
                            if (pix_done) begin
                                wr_en    <= 1'b1;
                                wr_data  <= pix_word;
                                wr_addr  <= cur_idx;
                                pix_buf  <= '0;
                                byte_cnt <= 1'b0;
                                if (cur_idx == LAST_IDX) begin
                                    last_pending <= 1'b1;
                                end
                            end else begin
                                pix_buf  <= pix_word;
                                byte_cnt <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        wr_addr <= '0;
                        state   <= (SYNC_EN != 0) ? ST_IDLE : ST_RECV;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader using three configurations:
// A = 4 pixels, 1 byte/pixel, sync header, 20-cycle timeout
// B = 2 pixels, 2 bytes/pixel, sync header
// C = 4 pixels, 1 byte/pixel, no sync header
module tb_uart_frame_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_frame_error = 1'b0;
    logic        abort = 1'b0;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0;

    logic [18:0] a_addr, b_addr, c_addr;
    logic [7:0]  a_data, c_data;
    logic [15:0] b_data;
    logic        a_wen, b_wen, c_wen;
    logic        a_done, b_done, c_done;
    logic        a_busy, b_busy, c_busy;
    logic [7:0]  a_err, b_err, c_err;
    logic [1:0]  a_state, b_state, c_state;

    int total = 0;
    int passed = 0;
    int a_wr_cnt = 0, b_wr_cnt = 0, b_done_cnt = 0, c_wr_cnt = 0;

    always #10 clk = ~clk;

    uart_frame_loader #(.ADDR_W(19), .FRAME_PIXELS(4), .BPP(1), .SYNC_EN(1),
                        .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(va),
        .rx_frame_error(rx_frame_error), .abort(abort),
        .wr_addr(a_addr), .wr_data(a_data), .wr_en(a_wen), .frame_done(a_done),
        .busy(a_busy), .error_count(a_err), .state(a_state));

    uart_frame_loader #(.ADDR_W(19), .FRAME_PIXELS(2), .BPP(2), .SYNC_EN(1),
                        .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(vb),
        .rx_frame_error(rx_frame_error), .abort(abort),
        .wr_addr(b_addr), .wr_data(b_data), .wr_en(b_wen), .frame_done(b_done),
        .busy(b_busy), .error_count(b_err), .state(b_state));

    uart_frame_loader #(.ADDR_W(19), .FRAME_PIXELS(4), .BPP(1), .SYNC_EN(0),
                        .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_CYCLES(500000)) dut_c (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(vc),
        .rx_frame_error(rx_frame_error), .abort(abort),
        .wr_addr(c_addr), .wr_data(c_data), .wr_en(c_wen), .frame_done(c_done),
        .busy(c_busy), .error_count(c_err), .state(c_state));

    // Running tallies of write strobes and frame_done pulses.
    always @(posedge clk) begin
        if (a_wen) a_wr_cnt <= a_wr_cnt + 1;
        if (b_wen) b_wr_cnt <= b_wr_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (c_wen) c_wr_cnt <= c_wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one byte to the selected DUT (0=A, 1=B, 2=C) for one clock.
    task automatic send(input int sel, input logic [7:0] b, input logic fe, input logic ab);
        @(negedge clk);
        rx_data = b; rx_frame_error = fe; abort = ab;
        va = (sel == 0); vb = (sel == 1); vc = (sel == 2);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0; rx_frame_error = 1'b0; abort = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", a_state); else passed++;
        total++; if ({a_addr, a_data, a_wen, a_done, a_busy, a_err} !== '0)
            $display("FAIL rst_outputs: got addr=%0d data=%h wen=%b done=%b busy=%b err=%0d want all 0",
                     a_addr, a_data, a_wen, a_done, a_busy, a_err); else passed++;
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0);
        total++; if (a_state !== 2'd2) $display("FAIL rst_hdr_recv: got %0d want 2", a_state); else passed++;
        send(0, 8'h01, 0, 0);
        total++; if (a_wen !== 1'b1 || a_data !== 8'h01) $display("FAIL rst_pre_write: got wen=%b data=%h want 1/01", a_wen, a_data); else passed++;
        #2 rst = 1'b1; #1;
        total++; if ({a_state, a_addr, a_data, a_wen, a_done, a_busy, a_err} !== '0)
            $display("FAIL rst_async: got state=%0d addr=%0d data=%h wen=%b busy=%b want all 0",
                     a_state, a_addr, a_data, a_wen, a_busy); else passed++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_frame();
        int w0;
        w0 = a_wr_cnt;
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send(0, 8'(i + 1), 0, 0);
            total++; if (a_wen !== 1'b1 || a_addr !== 19'(i) || a_data !== 8'(i + 1))
                $display("FAIL frame_write%0d: got wen=%b addr=%0d data=%h want 1/%0d/%h", i, a_wen, a_addr, a_data, i, i + 1); else passed++;
            tick();
            if (i < 3) begin
                total++; if (a_wen !== 1'b0 || a_addr !== 19'(i + 1))
                    $display("FAIL frame_incr%0d: got wen=%b addr=%0d want 0/%0d", i, a_wen, a_addr, i + 1); else passed++;
            end else begin
                total++; if (a_state !== 2'd3 || a_done !== 1'b1 || a_addr !== 19'd0)
                    $display("FAIL frame_done: got state=%0d done=%b addr=%0d want 3/1/0", a_state, a_done, a_addr); else passed++;
            end
        end
        tick();
        total++; if (a_state !== 2'd0 || a_done !== 1'b0) $display("FAIL frame_idle: got state=%0d done=%b want 0/0", a_state, a_done); else passed++;
        total++; if (a_wr_cnt - w0 !== 4) $display("FAIL frame_wr_count: got %0d want 4", a_wr_cnt - w0); else passed++;
    endtask

    task automatic test_bpp2();
        int w0, d0;
        do_reset();
        w0 = b_wr_cnt; d0 = b_done_cnt;
        send(1, 8'hAA, 0, 0); send(1, 8'h55, 0, 0); send(1, 8'h12, 0, 0);
        total++; if (b_wen !== 1'b0) $display("FAIL bpp2_half: got wen=%b want 0", b_wen); else passed++;
        send(1, 8'h34, 0, 0);
        total++; if (b_wen !== 1'b1 || b_addr !== 19'd0 || b_data !== 16'h1234)
            $display("FAIL bpp2_px0: got wen=%b addr=%0d data=%h want 1/0/1234", b_wen, b_addr, b_data); else passed++;
        send(1, 8'h56, 0, 0);
        total++; if (b_wen !== 1'b0 || b_addr !== 19'd1) $display("FAIL bpp2_mid: got wen=%b addr=%0d want 0/1", b_wen, b_addr); else passed++;
        send(1, 8'h78, 0, 0);
        total++; if (b_wen !== 1'b1 || b_addr !== 19'd1 || b_data !== 16'h5678)
            $display("FAIL bpp2_px1: got wen=%b addr=%0d data=%h want 1/1/5678", b_wen, b_addr, b_data); else passed++;
        tick();
        total++; if (b_done !== 1'b1 || b_state !== 2'd3) $display("FAIL bpp2_done: got done=%b state=%0d want 1/3", b_done, b_state); else passed++;
        repeat (3) tick();
        total++; if (b_wr_cnt - w0 !== 2 || b_done_cnt - d0 !== 1)
            $display("FAIL bpp2_counts: got writes=%0d dones=%0d want 2/1", b_wr_cnt - w0, b_done_cnt - d0); else passed++;
    endtask

    task automatic test_header();
        int w0;
        do_reset();
        send(0, 8'hAA, 0, 0); send(0, 8'hAA, 0, 0);
        total++; if (a_state !== 2'd1) $display("FAIL hdr_aa_aa: got %0d want 1", a_state); else passed++;
        send(0, 8'h55, 0, 0);
        total++; if (a_state !== 2'd2 || a_busy !== 1'b1) $display("FAIL hdr_recv: got state=%0d busy=%b want 2/1", a_state, a_busy); else passed++;
        send(0, 8'h05, 0, 0);
        total++; if (a_wen !== 1'b1 || a_addr !== 19'd0 || a_data !== 8'h05)
            $display("FAIL hdr_first_write: got wen=%b addr=%0d data=%h want 1/0/05", a_wen, a_addr, a_data); else passed++;
        do_reset();
        w0 = a_wr_cnt;
        send(0, 8'hAA, 0, 0); send(0, 8'h11, 0, 0);
        total++; if (a_state !== 2'd0) $display("FAIL hdr_bad_byte: got %0d want 0", a_state); else passed++;
        send(0, 8'h55, 0, 0); tick();
        total++; if (a_state !== 2'd0 || a_wr_cnt - w0 !== 0)
            $display("FAIL hdr_stay_idle: got state=%0d writes=%0d want 0/0", a_state, a_wr_cnt - w0); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0); send(0, 8'h01, 0, 0); send(0, 8'h02, 0, 0);
        repeat (19) tick();
        total++; if (a_state !== 2'd2 || a_err !== 8'd0) $display("FAIL to_early: got state=%0d err=%0d want 2/0", a_state, a_err); else passed++;
        tick();
        total++; if (a_state !== 2'd0 || a_err !== 8'd1 || a_addr !== 19'd0)
            $display("FAIL to_expire: got state=%0d err=%0d addr=%0d want 0/1/0", a_state, a_err, a_addr); else passed++;
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0); send(0, 8'h09, 0, 0);
        total++; if (a_wen !== 1'b1 || a_addr !== 19'd0 || a_data !== 8'h09)
            $display("FAIL to_restart: got wen=%b addr=%0d data=%h want 1/0/09", a_wen, a_addr, a_data); else passed++;
    endtask

    task automatic test_errors();
        do_reset();
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0); send(0, 8'h01, 0, 0); send(0, 8'h02, 0, 0);
        send(0, 8'h03, 1, 0);
        total++; if (a_state !== 2'd0 || a_wen !== 1'b0 || a_err !== 8'd1 || a_addr !== 19'd0)
            $display("FAIL ferr_recv: got state=%0d wen=%b err=%0d addr=%0d want 0/0/1/0", a_state, a_wen, a_err, a_addr); else passed++;
        send(0, 8'hAA, 0, 0); send(0, 8'h55, 0, 0); send(0, 8'h01, 0, 0);
        send(0, 8'h07, 0, 1);
        total++; if (a_state !== 2'd0 || a_wen !== 1'b0 || a_err !== 8'd1 || a_addr !== 19'd0)
            $display("FAIL abort: got state=%0d wen=%b err=%0d addr=%0d want 0/0/1/0", a_state, a_wen, a_err, a_addr); else passed++;
        send(0, 8'hAA, 1, 0);
        total++; if (a_state !== 2'd0 || a_err !== 8'd2)
            $display("FAIL ferr_idle: got state=%0d err=%0d want 0/2", a_state, a_err); else passed++;
        for (int i = 0; i < 260; i++) send(0, 8'h00, 1, 0);
        total++; if (a_err !== 8'd255) $display("FAIL err_saturate: got %0d want 255", a_err); else passed++;
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        tick();
        total++; if (c_state !== 2'd2) $display("FAIL b2b_auto_recv: got %0d want 2", c_state); else passed++;
        w0 = c_wr_cnt;
        for (int i = 0; i < 4; i++) begin
            send(2, 8'(8'h11 * (i + 1)), 0, 0);
            total++; if (c_wen !== 1'b1 || c_addr !== 19'(i) || c_data !== 8'(8'h11 * (i + 1)))
                $display("FAIL b2b_write%0d: got wen=%b addr=%0d data=%h want 1/%0d/%h", i, c_wen, c_addr, c_data, i, 8'h11 * (i + 1)); else passed++;
        end
        tick();
        total++; if (c_done !== 1'b1 || c_state !== 2'd3 || c_addr !== 19'd0)
            $display("FAIL b2b_done: got done=%b state=%0d addr=%0d want 1/3/0", c_done, c_state, c_addr); else passed++;
        tick();
        total++; if (c_state !== 2'd2 || c_done !== 1'b0) $display("FAIL b2b_rearm: got state=%0d done=%b want 2/0", c_state, c_done); else passed++;
        send(2, 8'h99, 0, 0);
        total++; if (c_wen !== 1'b1 || c_addr !== 19'd0 || c_data !== 8'h99)
            $display("FAIL b2b_next_frame: got wen=%b addr=%0d data=%h want 1/0/99", c_wen, c_addr, c_data); else passed++;
        total++; if (c_wr_cnt - w0 !== 4) $display("FAIL b2b_count: got %0d want 4", c_wr_cnt - w0); else passed++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bpp2();
        test_header();
        test_timeout();
        test_errors();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Parametrised successor to the fixed UART→BRAM write-address counter. Takes bytes from uart_rx, optionally waits for a 2-byte sync header, and packs 1 or 2 bytes per pixel. Issues sequential BRAM write commands and signals frame completion. Recovers from stalled transfers (timeout), UART frame errors and host abort. Sits between uart_rx and the write port of the dual-port image BRAM, all in the 50 MHz domain.

Parameters:
ADDR_W, 19, width of wr_addr.
FRAME_PIXELS, 307200, pixels per frame (640x480); legal range 2..2^ADDR_W.
BPP, 1, bytes per pixel; legal values 1 or 2.
SYNC_EN, 1, 1 = frame must be preceded by SYNC0,SYNC1; 0 = receive immediately.
SYNC0, 8'hAA, first header byte.
SYNC1, 8'h55, second header byte.
TIMEOUT_CYCLES, 500000, idle clocks tolerated inside a frame (10 ms at 50 MHz); must be ≥1.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  byte from uart_rx
rx_valid  in  1  1-cycle strobe, rx_data valid
rx_frame_error  in  1  1-cycle strobe, current byte had a bad stop bit
abort  in  1  force return to IDLE, discard partial frame
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  8*BPP  BRAM write data
wr_en  out  1  BRAM write enable, 1-cycle pulse
frame_done  out  1  1-cycle pulse, last pixel of frame written
busy  out  1  high in SYNC1 and RECV
error_count  out  8  saturating count of timeouts and frame errors
state  out  2  current FSM state, debug

Behaviour:
- Reset (async assert, sync release): state=IDLE; wr_addr=0, wr_data=0, wr_en=0, frame_done=0, error_count=0; byte buffer and timeout counter cleared.
- State encoding: IDLE=0, SYNC1=1, RECV=2, DONE=3.
- IDLE
  - SYNC_EN=0: go to RECV on the next clock.
  - SYNC_EN=1: rx_valid with rx_data==SYNC0 → SYNC1; any other byte is ignored.
- SYNC1
  - rx_valid with SYNC1 → RECV.
  - rx_valid with SYNC0 → stay in SYNC1.
  - Any other byte → IDLE.
- RECV
  - Each valid byte fills the pixel buffer.
  - BPP=2: first byte is the MSB (wr_data[15:8]), second byte is the LSB.
  - On the byte completing a pixel, the next cycle drives wr_en=1 with wr_data=pixel and wr_addr=current pixel index (latency 1 clock from rx_valid).
  - wr_addr increments in the cycle after wr_en.
- Last pixel: the write to index FRAME_PIXELS-1 moves the FSM to DONE.
- DONE (one cycle): frame_done=1, wr_addr←0, then IDLE (SYNC_EN=1) or RECV (SYNC_EN=0).
- Back-to-back: rx_valid may be asserted every clock; no byte is lost in RECV.
- Bytes arriving during the DONE cycle are dropped.
- Timeout:
  - In SYNC1/RECV the counter increments each clock without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES → IDLE, wr_addr←0, pixel buffer cleared, error_count+1.
  - Counter is held at 0 in IDLE/DONE.
- Frame error: rx_frame_error with rx_valid in any state drops the byte.
  - In SYNC1/RECV: → IDLE, wr_addr←0, buffer cleared, error_count+1.
  - In IDLE: error_count+1 only.
- abort: highest priority of all events. Same-cycle rx_valid byte is dropped; → IDLE, wr_addr←0, buffer cleared; error_count unchanged.
- error_count saturates at 255.
- Precedence, highest first: abort, rx_frame_error, timeout, normal byte.
- wr_en never asserts outside RECV.

Test Plan:
- Reset mid-RECV (FRAME_PIXELS=4, BPP=1, SYNC_EN=1): after AA 55 01, assert rst → all outputs 0, state=0; then AA 55 01 02 03 04 → wr_en pulses at addr 0..3 with data 01..04, each 1 clock after rx_valid; frame_done one cycle after addr-3 write; wr_addr=0.
- BPP=2, FRAME_PIXELS=2: AA 55 12 34 56 78 → exactly two writes: addr0=16'h1234, addr1=16'h5678; frame_done once.
- Header errors: AA AA 55 05 → RECV entered, first write data 05. AA 11 55 → stays IDLE, no wr_en.
- Timeout (TIMEOUT_CYCLES=20): AA 55 01 02, then idle 20 clocks → state=IDLE, error_count=1, wr_addr=0. Next AA 55 09 → write at addr 0.
- Frame error and abort:
  - rx_frame_error with 3rd payload byte → IDLE, error_count+1, no write for that byte.
  - abort in the same cycle as rx_valid → byte dropped, IDLE, error_count unchanged.
- SYNC_EN=0, back-to-back rx_valid for 4 cycles (FRAME_PIXELS=4) → 4 consecutive wr_en pulses, frame_done, FSM returns to RECV, and the next byte writes at addr 0.
